hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_control_unit_reg_match.sv | 14 +
 rtl/hazard_control_unit.sv | 108 ++++++++++
 tb/tb_hazard_control_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and sizing for the pipeline hazard control unit.
package hazard_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_control_unit_reg_match.sv
// Register-specifier compare that treats the hard-wired zero register as never matching.
module reg_match
  import hazard_pkg::*;
#(
  parameter int unsigned W = hazard_pkg::REG_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         hit
);

  assign hit = (x == y) && (x != W'(ZERO_REG));

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / branch-operand stall control and IF/ID flush on redirect, with saturating
// stall and flush counters. Stall and flush decisions act in the same cycle they are detected.
module hazard_control_unit
#(
  parameter int unsigned REG_W = hazard_pkg::REG_W,
  parameter int unsigned CNT_W = hazard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_Branch,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [REG_W-1:0] IDEX_Rd,
  input  logic             EXMEM_MemRead,
  input  logic [REG_W-1:0] EXMEM_Rd,
  input  logic             BranchTaken,
  input  logic             Jump,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  import hazard_pkg::*;

  logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;

  reg_match #(.W(REG_W)) u_rs_ex  (.x(IDEX_Rd),  .y(IFID_Rs), .hit(rs_ex_hit));
  reg_match #(.W(REG_W)) u_rt_ex  (.x(IDEX_Rd),  .y(IFID_Rt), .hit(rt_ex_hit));
  reg_match #(.W(REG_W)) u_rs_mem (.x(EXMEM_Rd), .y(IFID_Rs), .hit(rs_mem_hit));
  reg_match #(.W(REG_W)) u_rt_mem (.x(EXMEM_Rd), .y(IFID_Rt), .hit(rt_mem_hit));

  logic ex_dep, mem_dep;
  logic load_use, br_alu, br_load, br_mem, stall_cond;

  assign ex_dep     = rs_ex_hit  || (IFID_UsesRt && rt_ex_hit);
  assign mem_dep    = rs_mem_hit || (IFID_UsesRt && rt_mem_hit);
  assign load_use   = IDEX_MemRead && ex_dep;
  assign br_alu     = IFID_Branch && IDEX_RegWrite && !IDEX_MemRead && ex_dep;
  assign br_load    = IFID_Branch && load_use;
  assign br_mem     = IFID_Branch && EXMEM_MemRead && mem_dep;
  assign stall_cond = load_use || br_alu || br_mem;

  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic       stall, flush;

  // Next state and same-cycle pipeline controls; reset forces the free-running values.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    stall       = 1'b0;
    flush       = 1'b0;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (stall_cond) begin
          stall   = 1'b1;
          rem_d   = br_load ? 2'd1 : 2'd0;
          state_d = (rem_d != 2'd0) ? STALL : RUN;
        end else if (BranchTaken || Jump) begin
          flush = 1'b1;
        end
      end
      STALL: begin
        stall   = 1'b1;
        rem_d   = rem_q - 2'd1;
        state_d = (rem_d == 2'd0) ? RUN : STALL;
      end
      default: begin
        state_d = RUN;
        rem_d   = 2'd0;
      end
    endcase
    if (!rst_n) begin
      stall = 1'b0;
      flush = 1'b0;
    end
    if (stall) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end
    IFID_Flush = flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      rem_q      <= 2'd0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (stall && (StallCount != {CNT_W{1'b1}})) StallCount <= StallCount + CNT_W'(1);
      if (flush && (FlushCount != {CNT_W{1'b1}})) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: stall lengths, zero register, redirect priority,
// reset mid-stall and counter saturation.
module tb_hazard_control_unit;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] IFID_Rs, IFID_Rt, IDEX_Rd, EXMEM_Rd;
  logic             IFID_UsesRt, IFID_Branch, IDEX_MemRead, IDEX_RegWrite;
  logic             EXMEM_MemRead, BranchTaken, Jump;
  logic             PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IFID_Branch(IFID_Branch), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_Rd(IDEX_Rd),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_Rd(EXMEM_Rd),
    .BranchTaken(BranchTaken), .Jump(Jump),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected pipeline controls: s=1 means a stall cycle, f is the flush value.
  task automatic check_ctl(input string tag, input logic s, input logic f);
    check({tag, ".pcw"},    32'(PCWrite),     32'(!s));
    check({tag, ".ifidw"},  32'(IFID_Write),  32'(!s));
    check({tag, ".bubble"}, 32'(IDEX_Bubble), 32'(s));
    check({tag, ".flush"},  32'(IFID_Flush),  32'(f));
  endtask

  task automatic check_cnt(input string tag, input int sc, input int fc);
    check({tag, ".stallcnt"}, 32'(StallCount), 32'(sc));
    check({tag, ".flushcnt"}, 32'(FlushCount), 32'(fc));
  endtask

  task automatic idle();
    IFID_Rs = '0; IFID_Rt = '0; IFID_UsesRt = 1'b0; IFID_Branch = 1'b0;
    IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_Rd = '0;
    EXMEM_MemRead = 1'b0; EXMEM_Rd = '0; BranchTaken = 1'b0; Jump = 1'b0;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic br_after_load();
    IDEX_MemRead = 1'b1; IDEX_Rd = 5'd9;
    IFID_Branch = 1'b1; IFID_Rt = 5'd9; IFID_UsesRt = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    // Reset holds outputs at free-running values even with a live load-use hazard.
    IDEX_MemRead = 1'b1; IDEX_Rd = 5'd3; IFID_Rs = 5'd3; BranchTaken = 1'b1;
    tick();
    sample();
    check_ctl("reset", 1'b0, 1'b0);
    check_cnt("reset", 0, 0);
    tick();
    idle();
    rst_n = 1'b1;

    // Load-use: one stall cycle.
    IDEX_MemRead = 1'b1; IDEX_Rd = 5'd8; IFID_Rs = 5'd8;
    sample(); check_ctl("lu.c0", 1'b1, 1'b0);
    tick(); idle();
    sample(); check_ctl("lu.c1", 1'b0, 1'b0);
    check_cnt("lu", 1, 0);

    // Register zero never creates a dependency.
    tick();
    IDEX_MemRead = 1'b1; IDEX_Rd = 5'd0; IFID_Rs = 5'd0;
    sample(); check_ctl("r0", 1'b0, 1'b0);
    tick(); idle();
    sample(); check_cnt("r0", 1, 0);

    // Rt match is ignored when the instruction does not read Rt.
    IDEX_MemRead = 1'b1; IDEX_Rd = 5'd4; IFID_Rt = 5'd4; IFID_UsesRt = 1'b0;
    sample(); check_ctl("nort", 1'b0, 1'b0);
    tick(); idle();

    // Branch after load: two stall cycles.
    br_after_load();
    sample(); check_ctl("bl.c0", 1'b1, 1'b0);
    tick(); idle();
    sample(); check_ctl("bl.c1", 1'b1, 1'b0);
    tick();
    sample(); check_ctl("bl.c2", 1'b0, 1'b0);
    check_cnt("bl", 3, 0);

    // Branch after ALU op: one stall cycle.
    tick();
    IFID_Branch = 1'b1; IDEX_RegWrite = 1'b1; IDEX_Rd = 5'd5; IFID_Rs = 5'd5;
    sample(); check_ctl("ba.c0", 1'b1, 1'b0);
    tick(); idle();
    sample(); check_ctl("ba.c1", 1'b0, 1'b0);
    check_cnt("ba", 4, 0);

    // Branch after load now in MEM: one stall cycle.
    tick();
    IFID_Branch = 1'b1; EXMEM_MemRead = 1'b1; EXMEM_Rd = 5'd7; IFID_Rt = 5'd7; IFID_UsesRt = 1'b1;
    sample(); check_ctl("bm.c0", 1'b1, 1'b0);
    tick(); idle();
    sample(); check_ctl("bm.c1", 1'b0, 1'b0);
    check_cnt("bm", 5, 0);

    // Redirect loses to a coincident stall, then flushes on its own.
    tick();
    IDEX_MemRead = 1'b1; IDEX_Rd = 5'd8; IFID_Rs = 5'd8; BranchTaken = 1'b1;
    sample(); check_ctl("rd.c0", 1'b1, 1'b0);
    tick(); idle(); BranchTaken = 1'b1;
    sample(); check_ctl("rd.c1", 1'b0, 1'b1);
    tick(); idle(); Jump = 1'b1;
    sample(); check_ctl("rd.jmp", 1'b0, 1'b1);
    check_cnt("rd", 6, 1);
    tick(); idle();
    sample(); check_ctl("rd.idle", 1'b0, 1'b0);
    check_cnt("rd.after", 6, 2);

    // A redirect during the second cycle of a branch-after-load stall is suppressed.
    br_after_load();
    tick(); idle(); BranchTaken = 1'b1;
    sample(); check_ctl("stl.redir", 1'b1, 1'b0);
    tick(); idle();
    sample(); check_cnt("stl.redir", 8, 2);

    // Reset during the second stall cycle abandons it.
    br_after_load();
    tick(); idle(); rst_n = 1'b0;
    sample(); check_ctl("rms.inrst", 1'b0, 1'b0);
    tick(); rst_n = 1'b1;
    sample(); check_ctl("rms.after", 1'b0, 1'b0);
    check_cnt("rms", 0, 0);

    // Continuous load-use saturates StallCount.
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_Rd = 5'd8; IFID_Rs = 5'd8;
    repeat (65536 + 5) @(posedge clk);
    #1;
    sample();
    check_ctl("sat", 1'b1, 1'b0);
    check_cnt("sat", 32'hFFFF, 0);
    tick();
    sample();
    check("sat.hold", 32'(StallCount), 32'hFFFF);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
